// File: rtl/grid_bist_pkg.sv
// Shared constants, FSM state type and pattern helpers for the RAM32 grid BIST.
package grid_bist_pkg;

   localparam int          NUM_BANKS = 64;
   localparam int          ADDR_W    = 5;
   localparam int          DATA_W    = 32;
   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
   localparam logic [7:0]  ERR_MAX   = 8'd255;

   typedef enum logic [2:0] {IDLE, FILL, READ, DRAIN, DONE} state_t;

   // Half of each byte pair is inverted, so the expanded seed is never zero.
   function automatic logic [31:0] seed_expand(input logic [7:0] s);
      return {s, ~s, s, ~s};
   endfunction

   // XOR-fold a data word down to one byte for the rolling signature.
   function automatic logic [7:0] fold8(input logic [31:0] w);
      return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
   endfunction

endpackage

// File: rtl/grid_lfsr32.sv
// 32-bit Galois LFSR with synchronous load; load takes priority over step.
module grid_lfsr32
   import grid_bist_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        step,
   output logic [31:0] value
);

   // Shift right and fold the mask back in whenever a one falls out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (step)
         value <= {1'b0, value[31:1]} ^ (value[0] ? LFSR_MASK : 32'h0);
   end

endmodule

// File: rtl/grid_ram_bist_sequencer.sv
// Fills every word of every RAM32 bank with an LFSR pattern, reads it back
// through a one-stage compare pipe and reports pass, error count and signature.
module grid_ram_bist_sequencer
   import grid_bist_pkg::*;
#(
   parameter int NUM_BANKS = grid_bist_pkg::NUM_BANKS,
   parameter int ADDR_W    = grid_bist_pkg::ADDR_W,
   parameter int DATA_W    = grid_bist_pkg::DATA_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic [7:0]                  seed,
   output logic [ADDR_W-1:0]           ram_a,
   output logic [DATA_W-1:0]           ram_d,
   output logic [NUM_BANKS-1:0]        ram_we,
   input  logic [NUM_BANKS*DATA_W-1:0] ram_q_flat,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic [7:0]                  err_count,
   output logic [7:0]                  signature
);

   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int IDX_W  = BANK_W + ADDR_W;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    index;
   logic [BANK_W-1:0]   bank, cmp_bank;
   logic [7:0]          seed_q;
   logic [31:0]         lfsr, lfsr_load_val, cmp_exp, q;
   logic                lfsr_load, lfsr_step, go, kill, cmp_vld, last_idx;

   assign bank     = index[IDX_W-1:ADDR_W];
   assign last_idx = &index;
   assign q        = ram_q_flat[int'(cmp_bank)*DATA_W +: DATA_W];

   grid_lfsr32 u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .load     (lfsr_load),
      .load_val (lfsr_load_val),
      .step     (lfsr_step),
      .value    (lfsr)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and LFSR control; abort beats start, and only bites while busy.
   always_comb begin
      state_nxt     = state;
      lfsr_load     = 1'b0;
      lfsr_step     = 1'b0;
      lfsr_load_val = seed_expand(seed_q);
      go            = 1'b0;
      kill          = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start && !abort) begin
               go            = 1'b1;
               state_nxt     = FILL;
               lfsr_load     = 1'b1;
               lfsr_load_val = seed_expand(seed);
            end
         end
         FILL: begin
            if (abort) begin
               kill      = 1'b1;
               state_nxt = IDLE;
            end else begin
               lfsr_step = 1'b1;
               if (last_idx) begin
                  state_nxt = READ;
                  lfsr_load = 1'b1;
               end
            end
         end
         READ: begin
            if (abort) begin
               kill      = 1'b1;
               state_nxt = IDLE;
            end else begin
               lfsr_step = 1'b1;
               if (last_idx) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            kill      = abort;
            state_nxt = abort ? IDLE : DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Word index walks bank-major through the grid in FILL and READ.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         index  <= '0;
         seed_q <= '0;
      end else if (go) begin
         index  <= '0;
         seed_q <= seed;
      end else if (!kill && (state == FILL || state == READ)) begin
         index <= index + 1'b1;
      end
   end

   // Compare pipe: remembers bank and expected word for the RAM's one-cycle read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_vld  <= 1'b0;
         cmp_bank <= '0;
         cmp_exp  <= '0;
      end else begin
         cmp_vld  <= (state == READ) && !kill;
         cmp_bank <= bank;
         cmp_exp  <= lfsr;
      end
   end

   // Error counter and signature; frozen by abort, cleared on start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
         signature <= '0;
      end else if (go) begin
         err_count <= '0;
         signature <= '0;
      end else if (cmp_vld && !kill) begin
         if (q != cmp_exp && err_count != ERR_MAX) err_count <= err_count + 8'd1;
         signature <= {signature[6:0], signature[7]} ^ fold8(q);
      end
   end

   // Done rises one cycle after DONE is entered and holds until the next start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 done <= 1'b0;
      else if (go)             done <= 1'b0;
      else if (state == DONE)  done <= 1'b1;
   end

   // RAM drives decode straight from state, so reset drops the write enables at once.
   assign busy   = (state == FILL) || (state == READ) || (state == DRAIN);
   assign pass   = done && (err_count == 8'd0);
   assign ram_a  = (state == FILL || state == READ) ? index[ADDR_W-1:0] : '0;
   assign ram_d  = (state == FILL) ? lfsr : '0;
   assign ram_we = (state == FILL) ? (NUM_BANKS'(1) << bank) : '0;

endmodule

// File: doc/grid_ram_bist_sequencer.md
Name: grid_ram_bist_sequencer

Overview:
- Upstream driver and downstream checker for the 64-bank RAM32 chiplet grid.
- On `start`, it writes a seeded LFSR pattern into every word of every bank, then reads every word back and compares it against the regenerated pattern.
- It reports a pass flag, a saturating error count and an 8-bit signature suitable for the `uo_out` pins.
- It replaces the tied-off A/D/WE drives at the top level.

Parameters:
- NUM_BANKS, 64, number of RAM32 instances driven.
- ADDR_W, 5, RAM32 word-address width (32 words).
- DATA_W, 32, RAM32 data width.

Ports:
- clk  in  1  single clock; also drives every RAM32 CLK.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled request to begin a run.
- abort  in  1  cancels a run in progress.
- seed  in  8  pattern seed, captured when start is accepted.
- ram_a  out  ADDR_W  word address shared by all banks.
- ram_d  out  DATA_W  write data shared by all banks.
- ram_we  out  NUM_BANKS  one-hot per-bank write enable.
- ram_q_flat  in  NUM_BANKS*DATA_W  concatenated bank outputs; bank b occupies bits [b*32 +: 32].
- busy  out  1  high in FILL, READ and DRAIN.
- done  out  1  high in DONE until the next start or reset.
- pass  out  1  valid when done is high; 1 iff err_count==0.
- err_count  out  8  mismatch count, saturating at 255.
- signature  out  8  rolling read-back signature.

Behaviour:
- Reset (async, active-high): state=IDLE. ram_we=0 immediately, not on the next edge. ram_a=0, ram_d=0, busy=0, done=0, pass=0, err_count=0, signature=0.
- RAM32 read latency is fixed at 1 cycle: address presented at edge n, Q valid and sampled at edge n+1.
- Seed expansion: lfsr_init = {seed, ~seed, seed, ~seed}. The result is never zero, so the LFSR cannot lock up.
- LFSR: 32-bit Galois with mask 0x80200003. Each step: shift right; if the shifted-out bit is 1, XOR with the mask. It steps once per write and once per read issue.
- Index counter: 11 bits = {bank[5:0], addr[4:0]}, increments by 1 per cycle in FILL and READ.
- IDLE/DONE -> FILL when start=1. On that edge:
  - capture seed and load lfsr_init;
  - clear index, err_count and signature;
  - clear done.
- FILL: each cycle drive ram_a=addr, ram_d=lfsr, ram_we=(1<<bank), then step the LFSR. After index 2047 -> READ, reload lfsr_init, index=0.
- ram_we is all-zero in every state except FILL.
- READ: each cycle drive ram_a=addr, latch {bank, expected=lfsr} into a 1-stage compare pipe, then step the LFSR. After index 2047 -> DRAIN.
- Compare stage, active in the cycle after every READ issue, including DRAIN:
  - q = ram_q_flat[bank_d*32 +: 32].
  - If q != expected_d, err_count += 1, saturating at 255.
  - signature <= {signature[6:0], signature[7]} ^ (q[31:24]^q[23:16]^q[15:8]^q[7:0]).
- DRAIN: one cycle for the final compare, then -> DONE.
- DONE: done=1, busy=0, pass=(err_count==0). Outputs hold until the next start.
- Timing: start sampled at edge k. Writes occur on edges k+1..k+2048; read issues on edges k+2049..k+4096; the last compare is at k+4097. done=1 after edge k+4098.
- start while busy=1 is ignored.
- abort=1 while busy:
  - -> IDLE on the next edge; ram_we=0 from that edge on;
  - done stays 0; err_count and signature hold their values.
- abort and start both high in IDLE: abort wins and nothing starts.
- abort in IDLE or DONE: no effect.
- Reset mid-run: same as power-on reset; any partial fill is abandoned.

Decomposition:
- Package grid_bist_pkg holds:
  - NUM_BANKS, ADDR_W, DATA_W, LFSR_MASK (0x80200003), ERR_MAX (255);
  - state enum {IDLE, FILL, READ, DRAIN, DONE};
  - function seed_expand(seed) -> 32 bits;
  - function fold8(word) -> 8 bits.
- One sub-module, grid_lfsr32: ports clk, rst, load, load_val, step, value. It is instantiated once and reloaded between phases.

Test Plan:
- seed=0xA5, clean behavioural RAM32 models -> first write is bank0 addr0 D=0xA55AA55A with ram_we=0x1. done=1 exactly 4098 cycles after start; pass=1; err_count=0; signature equals the golden model.
- Flip bit 0 of bank17 addr3 in its model after FILL -> err_count=1, pass=0; signature differs from the clean-run value.
- Bank 40 model Q stuck at 0 -> err_count=32, pass=0; ram_we never has more than one bit set (checked every cycle).
- All models return 0 -> err_count saturates at 255 without wrapping; pass=0.
- Run checks:
  - start pulsed again at cycle 100 of FILL -> ignored; done timing unchanged.
  - abort at cycle 1500 -> IDLE next edge, ram_we=0, done=0.
  - a new start then completes normally with pass=1.
- Assert rst at cycle 3000 (mid-READ) -> same cycle: ram_we=0, busy=0, err_count=0, signature=0. A start after rst falls runs to pass=1.
